// File: rtl/fizzbuzz_stream.sv
// Streams the numbers 1..G_LENGTH with two divisor flags on a valid/ready
// interface. The flags come from residue counters that step with the number,
// so no divider is needed. Supports one-shot or wrap-around mode, consumer
// backpressure, and a synchronous abort.
module fizzbuzz_stream #(
    parameter int unsigned G_LENGTH   = 100,
    parameter int unsigned G_DIV_FIZZ = 3,
    parameter int unsigned G_DIV_BUZZ = 5,
    localparam int unsigned W         = $clog2(G_LENGTH + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_continuous,
    input  logic         i_abort,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_number,
    output logic         o_is_fizz,
    output logic         o_is_buzz,
    output logic         o_last,
    output logic         o_busy
);

    // A divisor of 1 still gets a 1-bit residue, which stays at zero.
    localparam int unsigned FW = (G_DIV_FIZZ > 1) ? $clog2(G_DIV_FIZZ) : 1;
    localparam int unsigned BW = (G_DIV_BUZZ > 1) ? $clog2(G_DIV_BUZZ) : 1;

    localparam logic [W-1:0]  NumLast   = W'(G_LENGTH);
    localparam logic [W-1:0]  NumFirst  = W'(1);
    localparam logic [FW-1:0] FizzLast  = FW'(G_DIV_FIZZ - 1);
    localparam logic [BW-1:0] BuzzLast  = BW'(G_DIV_BUZZ - 1);
    // The residue of 1 is 1, except when the divisor is 1 (then it is 0).
    localparam logic [FW-1:0] FizzFirst = (G_DIV_FIZZ == 1) ? FW'(0) : FW'(1);
    localparam logic [BW-1:0] BuzzFirst = (G_DIV_BUZZ == 1) ? BW'(0) : BW'(1);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t        state_q;
    logic [W-1:0]  number_q;
    logic [FW-1:0] fizz_q;
    logic [BW-1:0] buzz_q;
    logic          cont_q;

    // Sequencer: tracks the state, the current number, both residues and the latched mode.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            number_q <= '0;
            fizz_q   <= '0;
            buzz_q   <= '0;
            cont_q   <= 1'b0;
        end else if (i_abort) begin
            // Abort wins over start and transfer; the presented element is dropped.
            state_q  <= StIdle;
            number_q <= '0;
            fizz_q   <= '0;
            buzz_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q  <= StRun;
                        number_q <= NumFirst;
                        fizz_q   <= FizzFirst;
                        buzz_q   <= BuzzFirst;
                        cont_q   <= i_continuous;
                    end
                end
                StRun: begin
                    if (i_ready) begin
                        if (number_q == NumLast) begin
                            if (cont_q) begin
                                number_q <= NumFirst;
                                fizz_q   <= FizzFirst;
                                buzz_q   <= BuzzFirst;
                            end else begin
                                state_q  <= StIdle;
                                number_q <= '0;
                                fizz_q   <= '0;
                                buzz_q   <= '0;
                            end
                        end else begin
                            number_q <= number_q + W'(1);
                            fizz_q   <= (fizz_q == FizzLast) ? '0 : fizz_q + FW'(1);
                            buzz_q   <= (buzz_q == BuzzLast) ? '0 : buzz_q + BW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode: depends only on registered state, so it is stable while stalled.
    always_comb begin
        o_busy    = (state_q == StRun);
        o_valid   = o_busy;
        o_number  = number_q;
        o_is_fizz = o_busy && (fizz_q == '0);
        o_is_buzz = o_busy && (buzz_q == '0);
        o_last    = o_busy && (number_q == NumLast);
    end

endmodule

// File: tb/tb_fizzbuzz_stream.sv
// Bench for fizzbuzz_stream: a default instance (100, 3, 5) and a small
// instance (7, 2, 1), each compared every cycle against an arithmetic model,
// plus hand-computed expectations for each scenario.
module tb_fizzbuzz_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic       a_start = 0, a_cont = 0, a_abort = 0, a_ready = 1;
    logic       a_valid, a_fizz, a_buzz, a_last, a_busy;
    logic [6:0] a_number;

    // Small instance
    logic       b_start = 0, b_cont = 0, b_abort = 0, b_ready = 1;
    logic       b_valid, b_fizz, b_buzz, b_last, b_busy;
    logic [2:0] b_number;

    fizzbuzz_stream dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_continuous(a_cont),
        .i_abort(a_abort), .i_ready(a_ready), .o_valid(a_valid), .o_number(a_number),
        .o_is_fizz(a_fizz), .o_is_buzz(a_buzz), .o_last(a_last), .o_busy(a_busy)
    );

    fizzbuzz_stream #(.G_LENGTH(7), .G_DIV_FIZZ(2), .G_DIV_BUZZ(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_continuous(b_cont),
        .i_abort(b_abort), .i_ready(b_ready), .o_valid(b_valid), .o_number(b_number),
        .o_is_fizz(b_fizz), .o_is_buzz(b_buzz), .o_last(b_last), .o_busy(b_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: whether an element is being presented, which number, and the mode.
    typedef struct packed {
        logic       busy;
        logic       cont;
        logic [7:0] num;
    } mstate_t;

    function automatic mstate_t mstep(input mstate_t s, input logic start, input logic cont,
                                      input logic abort, input logic ready, input int len);
        mstate_t n = s;
        if (abort) begin
            n.busy = 1'b0;
            n.num  = 8'd0;
        end else if (!s.busy) begin
            if (start) begin
                n.busy = 1'b1;
                n.num  = 8'd1;
                n.cont = cont;
            end
        end else if (ready) begin
            if (int'(s.num) == len) begin
                if (s.cont) n.num = 8'd1;
                else begin
                    n.busy = 1'b0;
                    n.num  = 8'd0;
                end
            end else begin
                n.num = s.num + 8'd1;
            end
        end
        return n;
    endfunction

    mstate_t ma, mb;
    int xfer_a = 0, last_a = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            if (ma.busy && a_ready && !a_abort) begin
                xfer_a <= xfer_a + 1;
                if (ma.num == 8'd100) last_a <= last_a + 1;
            end
            ma <= mstep(ma, a_start, a_cont, a_abort, a_ready, 100);
            mb <= mstep(mb, b_start, b_cont, b_abort, b_ready, 7);
        end
    end

    task automatic cmp(input string tag, input logic v, input logic [7:0] n, input logic f,
                       input logic bz, input logic l, input logic by, input mstate_t m,
                       input int fd, input int bd, input int len);
        check({tag, "_valid"}, 32'(v), 32'(m.busy));
        check({tag, "_number"}, 32'(n), 32'(m.num));
        check({tag, "_fizz"}, 32'(f), 32'(m.busy && (int'(m.num) % fd == 0)));
        check({tag, "_buzz"}, 32'(bz), 32'(m.busy && (int'(m.num) % bd == 0)));
        check({tag, "_last"}, 32'(l), 32'(m.busy && (int'(m.num) == len)));
        check({tag, "_busy"}, 32'(by), 32'(m.busy));
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp("a", a_valid, {1'b0, a_number}, a_fizz, a_buzz, a_last, a_busy, ma, 3, 5, 100);
        cmp("b", b_valid, {5'b0, b_number}, b_fizz, b_buzz, b_last, b_busy, mb, 2, 1, 7);
    end

    task automatic wait_num(input int target, input int budget);
        int k = 0;
        while (!(a_valid && int'(a_number) == target) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) check("wait_num_timeout", 32'(target), 32'hFFFF_FFFF);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (a_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) check("wait_idle_timeout", 32'(a_busy), 32'd0);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    initial begin
        int fizz_n, buzz_n, both_n, last_n, base_x, base_l, k;
        logic [6:0] fp, bp, lp;

        // Reset state, before any clock edge
        #1;
        check("rst_valid", 32'(a_valid), 0);
        check("rst_number", 32'(a_number), 0);
        check("rst_busy", 32'(a_busy), 0);
        @(negedge clk) rst = 1'b0;

        // 1: one-shot run with the consumer always ready
        base_x = xfer_a; base_l = last_a;
        fizz_n = 0; buzz_n = 0; both_n = 0; last_n = 0;
        pulse_start_a();
        for (int i = 1; i <= 100; i++) begin
            check("t1_valid", 32'(a_valid), 1);
            check("t1_seq", 32'(a_number), 32'(i));
            fizz_n += int'(a_fizz);
            buzz_n += int'(a_buzz);
            if (a_fizz && a_buzz) begin
                both_n++;
                check("t1_both_at_15k", 32'(a_number % 7'd15), 0);
            end
            if (a_last) begin
                last_n++;
                check("t1_last_at", 32'(a_number), 100);
            end
            @(negedge clk);
        end
        check("t1_valid_after", 32'(a_valid), 0);
        check("t1_fizz_count", 32'(fizz_n), 33);
        check("t1_buzz_count", 32'(buzz_n), 20);
        check("t1_both_count", 32'(both_n), 6);
        check("t1_last_count", 32'(last_n), 1);
        check("t1_xfers", 32'(xfer_a - base_x), 100);

        // 2: backpressure while 6 is presented
        base_x = xfer_a; base_l = last_a;
        pulse_start_a();
        wait_num(6, 20);
        a_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t2_hold_num", 32'(a_number), 6);
            check("t2_hold_fizz", 32'(a_fizz), 1);
        end
        a_ready = 1'b1;
        @(negedge clk);
        check("t2_next_num", 32'(a_number), 7);
        check("t2_next_fizz", 32'(a_fizz), 0);
        wait_idle(200);
        check("t2_xfers", 32'(xfer_a - base_x), 100);
        check("t2_lasts", 32'(last_a - base_l), 1);

        // 3: continuous mode, three wraps, stray starts during RUN
        base_x = xfer_a; base_l = last_a;
        a_cont = 1'b1;
        pulse_start_a();
        k = 0;
        while ((xfer_a - base_x) < 300 && k < 400) begin
            a_start = (k % 7 == 3);
            @(negedge clk);
            k++;
        end
        a_start = 1'b0;
        if (k >= 400) check("t3_timeout", 32'(xfer_a - base_x), 300);
        check("t3_lasts", 32'(last_a - base_l), 3);
        check("t3_still_busy", 32'(a_busy), 1);
        a_cont = 1'b0;
        wait_num(100, 200);
        check("t3_last_flag", 32'(a_last), 1);
        @(negedge clk);
        check("t3_wrap_num", 32'(a_number), 1);
        check("t3_wrap_fizz", 32'(a_fizz), 0);
        check("t3_wrap_buzz", 32'(a_buzz), 0);
        a_abort = 1'b1;
        @(negedge clk) a_abort = 1'b0;
        check("t3_abort_idle", 32'(a_busy), 0);

        // 4: abort at 42 with the consumer ready
        base_x = xfer_a;
        pulse_start_a();
        wait_num(42, 60);
        a_abort = 1'b1;
        @(negedge clk) a_abort = 1'b0;
        check("t4_valid", 32'(a_valid), 0);
        check("t4_number", 32'(a_number), 0);
        check("t4_busy", 32'(a_busy), 0);
        check("t4_delivered", 32'(xfer_a - base_x), 41);
        a_abort = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_abort = 1'b0; a_start = 1'b0;
        check("t4_abort_start_idle", 32'(a_busy), 0);
        a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        check("t4_restart_num", 32'(a_number), 1);
        check("t4_restart_valid", 32'(a_valid), 1);

        // 5: asynchronous reset between edges at 50
        wait_num(50, 80);
        #2 rst = 1'b1;
        #1;
        check("t5_valid", 32'(a_valid), 0);
        check("t5_number", 32'(a_number), 0);
        check("t5_flags", 32'({a_fizz, a_buzz, a_last}), 0);
        check("t5_busy", 32'(a_busy), 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t5_stays_idle", 32'(a_valid), 0);
        end

        // 6: small instance, one-shot
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        fp = '0; bp = '0; lp = '0;
        for (int i = 0; i < 7; i++) begin
            check("t6_seq", 32'(b_number), 32'(i + 1));
            fp[i] = b_fizz;
            bp[i] = b_buzz;
            lp[i] = b_last;
            @(negedge clk);
        end
        check("t6_valid_after", 32'(b_valid), 0);
        check("t6_fizz_pattern", 32'(fp), 32'h2A);
        check("t6_buzz_pattern", 32'(bp), 32'h7F);
        check("t6_last_pattern", 32'(lp), 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
